// File: rtl/fft_dma_ctrl_param.sv
// fft_dma_ctrl_param
//   DMA front-end for FFT cores. For each of conf_info_batches batches it
//   reads N_POINTS complex samples (VALS_PER_BEAT per beat), pulses
//   core_start, waits for core_done, then writes N_POINTS results back at
//   out_offset + batch*BEATS. All channels use valid/ready handshakes.
//
// Ports
//   clk, rst                    clock, async active-low reset
//   conf_done, conf_info_*      run configuration, sampled in IDLE only
//   dma_read_ctrl_*             read request   (index/length in beats)
//   dma_read_chnl_*             read data      (slot j = bits [32j+31:32j])
//   dma_write_ctrl_*            write request
//   dma_write_chnl_*            write data     (16-bit sign-extended halves)
//   core_start / core_done      core handshake
//   core_in_* / core_out_*      flat sample buses, point k at [k*SAMPLE_W +: SAMPLE_W]
//   acc_done                    all batches complete, held until conf_done drops
//   debug                       {state, 12'd0, batch[15:0]}
module fft_dma_ctrl_param #(
  parameter int         N_POINTS      = 64,
  parameter int         SAMPLE_W      = 12,
  parameter int         VALS_PER_BEAT = 2,
  parameter int         DMA_W         = 64,
  parameter logic [2:0] DMA_SIZE      = 3'd3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         conf_done,
  input  logic [31:0]                  conf_info_batches,
  input  logic [31:0]                  conf_info_out_offset,
  output logic                         dma_read_ctrl_valid,
  input  logic                         dma_read_ctrl_ready,
  output logic [31:0]                  dma_read_ctrl_data_index,
  output logic [31:0]                  dma_read_ctrl_data_length,
  output logic [2:0]                   dma_read_ctrl_data_size,
  input  logic                         dma_read_chnl_valid,
  output logic                         dma_read_chnl_ready,
  input  logic [DMA_W-1:0]             dma_read_chnl_data,
  output logic                         dma_write_ctrl_valid,
  input  logic                         dma_write_ctrl_ready,
  output logic [31:0]                  dma_write_ctrl_data_index,
  output logic [31:0]                  dma_write_ctrl_data_length,
  output logic [2:0]                   dma_write_ctrl_data_size,
  output logic                         dma_write_chnl_valid,
  input  logic                         dma_write_chnl_ready,
  output logic [DMA_W-1:0]             dma_write_chnl_data,
  output logic                         core_start,
  input  logic                         core_done,
  output logic [N_POINTS*SAMPLE_W-1:0] core_in_real,
  output logic [N_POINTS*SAMPLE_W-1:0] core_in_imag,
  input  logic [N_POINTS*SAMPLE_W-1:0] core_out_real,
  input  logic [N_POINTS*SAMPLE_W-1:0] core_out_imag,
  output logic                         acc_done,
  output logic [31:0]                  debug
);

  localparam int BEATS = N_POINTS / VALS_PER_BEAT;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int PW    = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_DATA, S_CORE_GO, S_CORE_WAIT, S_WR_REQ, S_WR_DATA, S_DONE
  } state_t;

  state_t                             state_q;
  logic [31:0]                        batches_q, out_off_q, batch_q;
  logic [BW-1:0]                      beat_q;
  logic                               rd_ctrl_valid_q, rd_chnl_ready_q;
  logic [31:0]                        rd_idx_q, rd_len_q;
  logic                               wr_ctrl_valid_q, wr_chnl_valid_q;
  logic [31:0]                        wr_idx_q, wr_len_q;
  logic [DMA_W-1:0]                   wr_data_q;
  logic [2:0]                         size_q;
  logic                               core_start_q, acc_done_q;
  logic [N_POINTS-1:0][SAMPLE_W-1:0]  in_re_q, in_im_q;
  logic [N_POINTS-1:0][SAMPLE_W-1:0]  out_re, out_im;

  assign out_re = core_out_real;
  assign out_im = core_out_imag;

  // Point index of slot j within beat b.
  function automatic logic [PW-1:0] pt(input logic [BW-1:0] b, input int j);
    return PW'(int'(b) * VALS_PER_BEAT + j);
  endfunction

  // Output beat b: each component sign-extended into its 16-bit half-slot.
  function automatic logic [DMA_W-1:0] pack_beat(input logic [BW-1:0] b);
    logic [DMA_W-1:0] d;
    d = '0;
    for (int j = 0; j < VALS_PER_BEAT; j++) begin
      d[32*j +: 16]      = 16'($signed(out_re[pt(b, j)]));
      d[32*j + 16 +: 16] = 16'($signed(out_im[pt(b, j)]));
    end
    return d;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      batches_q       <= '0;
      out_off_q       <= '0;
      batch_q         <= '0;
      beat_q          <= '0;
      rd_ctrl_valid_q <= 1'b0;
      rd_chnl_ready_q <= 1'b0;
      rd_idx_q        <= '0;
      rd_len_q        <= '0;
      wr_ctrl_valid_q <= 1'b0;
      wr_chnl_valid_q <= 1'b0;
      wr_idx_q        <= '0;
      wr_len_q        <= '0;
      wr_data_q       <= '0;
      size_q          <= '0;
      core_start_q    <= 1'b0;
      acc_done_q      <= 1'b0;
      in_re_q         <= '0;
      in_im_q         <= '0;
    end else begin
      size_q <= DMA_SIZE;
      case (state_q)
        S_IDLE: if (conf_done) begin
          batches_q <= conf_info_batches;
          out_off_q <= conf_info_out_offset;
          batch_q   <= '0;
          if (conf_info_batches == 32'd0) begin
            state_q    <= S_DONE;
            acc_done_q <= 1'b1;
          end else begin
            state_q         <= S_RD_REQ;
            rd_ctrl_valid_q <= 1'b1;
            rd_idx_q        <= '0;
            rd_len_q        <= 32'(BEATS);
          end
        end
        S_RD_REQ: if (rd_ctrl_valid_q && dma_read_ctrl_ready) begin
          rd_ctrl_valid_q <= 1'b0;
          rd_chnl_ready_q <= 1'b1;
          beat_q          <= '0;
          state_q         <= S_RD_DATA;
        end
        S_RD_DATA: if (rd_chnl_ready_q && dma_read_chnl_valid) begin
          for (int j = 0; j < VALS_PER_BEAT; j++) begin
            in_re_q[pt(beat_q, j)] <= dma_read_chnl_data[32*j +: SAMPLE_W];
            in_im_q[pt(beat_q, j)] <= dma_read_chnl_data[32*j + 16 +: SAMPLE_W];
          end
          if (beat_q == BW'(BEATS - 1)) begin
            rd_chnl_ready_q <= 1'b0;
            core_start_q    <= 1'b1;
            state_q         <= S_CORE_GO;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        // start is high for the single cycle spent here; done is ignored
        S_CORE_GO: begin
          core_start_q <= 1'b0;
          state_q      <= S_CORE_WAIT;
        end
        S_CORE_WAIT: if (core_done) begin
          wr_ctrl_valid_q <= 1'b1;
          wr_idx_q        <= out_off_q + batch_q * 32'(BEATS);
          wr_len_q        <= 32'(BEATS);
          state_q         <= S_WR_REQ;
        end
        // first beat is preloaded with the request handshake so the data
        // phase streams at one beat per cycle
        S_WR_REQ: if (wr_ctrl_valid_q && dma_write_ctrl_ready) begin
          wr_ctrl_valid_q <= 1'b0;
          beat_q          <= '0;
          wr_chnl_valid_q <= 1'b1;
          wr_data_q       <= pack_beat('0);
          state_q         <= S_WR_DATA;
        end
        S_WR_DATA: if (wr_chnl_valid_q && dma_write_chnl_ready) begin
          if (beat_q == BW'(BEATS - 1)) begin
            wr_chnl_valid_q <= 1'b0;
            batch_q         <= batch_q + 32'd1;
            if (batch_q + 32'd1 < batches_q) begin
              rd_ctrl_valid_q <= 1'b1;
              rd_idx_q        <= (batch_q + 32'd1) * 32'(BEATS);
              rd_len_q        <= 32'(BEATS);
              state_q         <= S_RD_REQ;
            end else begin
              acc_done_q <= 1'b1;
              state_q    <= S_DONE;
            end
          end else begin
            beat_q    <= beat_q + 1'b1;
            wr_data_q <= pack_beat(beat_q + 1'b1);
          end
        end
        S_DONE: if (!conf_done) begin
          acc_done_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dma_read_ctrl_valid        = rd_ctrl_valid_q;
  assign dma_read_ctrl_data_index   = rd_idx_q;
  assign dma_read_ctrl_data_length  = rd_len_q;
  assign dma_read_ctrl_data_size    = size_q;
  assign dma_read_chnl_ready        = rd_chnl_ready_q;
  assign dma_write_ctrl_valid       = wr_ctrl_valid_q;
  assign dma_write_ctrl_data_index  = wr_idx_q;
  assign dma_write_ctrl_data_length = wr_len_q;
  assign dma_write_ctrl_data_size   = size_q;
  assign dma_write_chnl_valid       = wr_chnl_valid_q;
  assign dma_write_chnl_data        = wr_data_q;
  assign core_start                 = core_start_q;
  assign core_in_real               = in_re_q;
  assign core_in_imag               = in_im_q;
  assign acc_done                   = acc_done_q;
  assign debug                      = {1'b0, state_q, 12'd0, batch_q[15:0]};

  // bits of the read beat outside the sample fields carry no information
  logic unused_rd_bits;
  assign unused_rd_bits = ^dma_read_chnl_data;

endmodule

// File: doc/fft_dma_ctrl_param.md
Name: fft_dma_ctrl_param

Overview:
Parametrised DMA front-end for our FFT cores. It supersedes the fixed 64-point single-pass wrapper. It runs a configurable number of batches, each as read N points, start core, wait for core done, write N points. It packs several samples per DMA beat and uses full valid/ready handshakes on every channel. The block sits between the platform DMA interface and any combinational or multi-cycle FFT core that exposes flat sample buses and a start/done pair.

Parameters:
N_POINTS, 64, FFT points per batch; a power of two, multiple of VALS_PER_BEAT.
SAMPLE_W, 12, bits per real/imag component; 2..16.
VALS_PER_BEAT, 2, complex samples per DMA beat; 1, 2 or 4.
DMA_W, 64, DMA channel data width; must be at least 32*VALS_PER_BEAT.
DMA_SIZE, 3'd3, value driven on both ctrl_data_size ports.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
conf_done  in  1  configuration valid (level)
conf_info_batches  in  32  number of batches; 0 is legal
conf_info_out_offset  in  32  beat index of the output region
dma_read_ctrl_valid/ready  out/in  1/1  read request handshake
dma_read_ctrl_data_index, _length  out  32 each  beat index, beat count
dma_read_ctrl_data_size  out  3  DMA_SIZE
dma_read_chnl_valid/ready  in/out  1/1  read data handshake
dma_read_chnl_data  in  DMA_W  read data
dma_write_ctrl_valid/ready  out/in  1/1  write request handshake
dma_write_ctrl_data_index, _length  out  32 each  beat index, beat count
dma_write_ctrl_data_size  out  3  DMA_SIZE
dma_write_chnl_valid/ready  out/in  1/1  write data handshake
dma_write_chnl_data  out  DMA_W  write data
core_start  out  1  one-cycle start pulse
core_done  in  1  core result valid (level or pulse)
core_in_real, core_in_imag  out  N_POINTS*SAMPLE_W each  flat input buffers; point k at [k*SAMPLE_W +: SAMPLE_W]
core_out_real, core_out_imag  in  N_POINTS*SAMPLE_W each  flat core results
acc_done  out  1  all batches complete
debug  out  32  {state[3:0], 12'd0, batch[15:0]}

Behaviour:
- Derived constants: BEATS = N_POINTS/VALS_PER_BEAT. Slot j of a beat occupies bits [32j+31:32j]. Real is in slot bits [SAMPLE_W-1:0]; imag is in slot bits [16+SAMPLE_W-1:16].
- Reset: every output is 0, state = IDLE, counters and buffers are 0. Reset asserted mid-operation aborts immediately; no outstanding handshake is completed.
- States: IDLE, RD_REQ, RD_DATA, CORE_GO, CORE_WAIT, WR_REQ, WR_DATA, DONE.
- IDLE: when conf_done=1, latch batches and out_offset and set batch=0. If batches==0, go to DONE; otherwise go to RD_REQ.
- RD_REQ:
  - read_ctrl_valid=1, index=batch*BEATS, length=BEATS.
  - On valid&&ready: drop valid next cycle, beat=0, go to RD_DATA.
  - index, length and size are held stable while valid is high.
- RD_DATA:
  - read_chnl_ready=1 while beat<BEATS.
  - On each valid&&ready, store VALS_PER_BEAT samples at points beat*VALS_PER_BEAT+j and increment beat.
  - After the last accepted beat, ready=0 the next cycle and go to CORE_GO.
  - Data bits outside the used slots are ignored.
- CORE_GO: core_start=1 for exactly one cycle, then go to CORE_WAIT. core_done is not sampled in CORE_GO.
- CORE_WAIT: on core_done=1 go to WR_REQ. There is no timeout. The core holds its outputs until the next core_start.
- WR_REQ: write_ctrl_valid=1, index=out_offset+batch*BEATS, length=BEATS. The handshake rule is the same as RD_REQ. Afterwards beat=0 and go to WR_DATA.
- WR_DATA:
  - write_chnl_valid is registered.
  - data packs points beat*VALS_PER_BEAT+j. Each component is sign-extended to 16 bits in its half-slot; unused slots are 0.
  - data and valid stay constant while valid&&!ready.
  - On valid&&ready the next beat is presented in the following cycle, giving back-to-back throughput of 1 beat/cycle.
  - After beat BEATS-1 is accepted, valid=0 and batch increments. If batch+1<batches go to RD_REQ, otherwise go to DONE.
- DONE: acc_done=1, held until conf_done=0; then acc_done=0 and go to IDLE. No new run starts while conf_done stays high.
- conf_done or config changes during a run are ignored.
- Latency floor per batch with all readies high: 2 + BEATS + 1 + 1 + core latency + 2 + BEATS cycles.

Test Plan:
- Defaults, batches=1, readies high, read data with point k real=k and imag=-k, core is an identity stub with done one cycle after start -> one read request {index 0, length 32}, one core_start pulse, one write request {index out_offset, length 32}, 32 write beats with slot0 = {16'hFFFF-ish sign-extended -2b, 2b}, then acc_done=1.
- batches=3, out_offset=100 -> read indices 0, 32, 64; write indices 100, 132, 164; acc_done only after the 96th write beat.
- Random write_chnl_ready drop pattern (30%) -> write data never changes while valid&&!ready, no beat is lost or duplicated, beat count is 32 per batch.
- read_chnl_valid gaps and a ready stall on read_ctrl for 5 cycles -> index stays stable, captured buffer is correct, core_start is asserted only after all 32 beats.
- batches=0 -> no DMA request, acc_done=1 two cycles after conf_done; conf_done low -> acc_done=0, IDLE.
- rst pulled low in WR_DATA at beat 10 -> all outputs 0 the same cycle; a rerun after release completes normally.
